text_mode_renderer: RTL and testbench

Pixel-generation stage directly downstream of the video sync generator. It consumes the per-pixel hpos/vpos/visible/hsync/vsync stream and renders an 80x30 text screen of 8x16 glyphs. It reads a synchronous character/attribute RAM, then a synchronous font ROM, and applies colour, blink and cursor. It emits 3-bit-per-channel RGB with hsync/vsync delayed to stay pixel-aligned with the RGB.

---
 rtl/text_mode_renderer.sv | 195 +++++++++++++++++++
 tb/tb_text_mode_renderer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/text_mode_renderer.sv
// ============================================================================
//  Module   : text_mode_renderer
//  Purpose  : 80x30 text-mode pixel generator (8x16 glyphs). Looks up the
//             character/attribute RAM, then the font ROM, and applies colour,
//             blink and an underline cursor. Sync outputs are delayed so they
//             stay pixel-aligned with the RGB outputs (5-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_mode_renderer #(
  parameter int COLS              = 80,
  parameter int ROWS              = 30,
  parameter int BLINK_LOG2        = 5,
  parameter int CURSOR_FIRST_LINE = 14
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_visible,
  input  logic        i_hsync,
  input  logic        i_vsync,
  output logic [11:0] o_char_addr,
  input  logic [15:0] i_char_data,
  output logic [11:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  input  logic        i_cursor_en,
  input  logic [6:0]  i_cursor_col,
  input  logic [4:0]  i_cursor_row,
  output logic [2:0]  o_red,
  output logic [2:0]  o_green,
  output logic [2:0]  o_blue,
  output logic        o_hsync,
  output logic        o_vsync
);

  // Stage 1..4 sideband travelling alongside the memory lookups
  logic [2:0] s1_hlow, s2_hlow, s3_hlow, s4_hlow;
  logic [3:0] s1_vlow, s2_vlow;
  logic       s1_vis, s2_vis, s3_vis, s4_vis;
  logic       s1_hs, s2_hs, s3_hs, s4_hs;
  logic       s1_vs, s2_vs, s3_vs, s4_vs;
  logic       s1_cur, s2_cur, s3_cur, s4_cur;
  logic [2:0] s3_fg, s3_bg, s4_fg, s4_bg;
  logic       s3_blink, s4_blink;

  logic [7:0] frame_cnt;
  logic       cursor_hit;
  logic       pixel_bit;
  logic       blink_phase;
  logic       pixel_on;
  logic [2:0] colour;
  logic       unused_bits;

  // Attribute bit 11 is reserved; ROWS only documents the screen height
  // because addressing is intentionally left unclipped.
  assign unused_bits = ^{i_char_data[11], 32'(ROWS)};

  // Underline cursor: matching cell and in the bottom glyph scanlines
  assign cursor_hit = i_cursor_en
                   && (i_hpos[9:3] == i_cursor_col)
                   && (i_vpos[9:4] == {1'b0, i_cursor_row})
                   && (i_vpos[3:0] >= 4'(CURSOR_FIRST_LINE));

  // Stage 1: character address plus sideband capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_char_addr <= '0;
      s1_hlow     <= '0;
      s1_vlow     <= '0;
      s1_vis      <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_cur      <= 1'b0;
    end else begin
      o_char_addr <= 12'(i_vpos[9:4]) * 12'(COLS) + 12'(i_hpos[9:3]);
      s1_hlow     <= i_hpos[2:0];
      s1_vlow     <= i_vpos[3:0];
      s1_vis      <= i_visible;
      s1_hs       <= i_hsync;
      s1_vs       <= i_vsync;
      s1_cur      <= cursor_hit;
    end
  end

  // Stage 2: wait for the character RAM read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_hlow <= '0;
      s2_vlow <= '0;
      s2_vis  <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      s2_cur  <= 1'b0;
    end else begin
      s2_hlow <= s1_hlow;
      s2_vlow <= s1_vlow;
      s2_vis  <= s1_vis;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_cur  <= s1_cur;
    end
  end

  // Stage 3: font address from the character code, latch the attribute
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_font_addr <= '0;
      s3_fg       <= '0;
      s3_bg       <= '0;
      s3_blink    <= 1'b0;
      s3_hlow     <= '0;
      s3_vis      <= 1'b0;
      s3_hs       <= 1'b0;
      s3_vs       <= 1'b0;
      s3_cur      <= 1'b0;
    end else begin
      o_font_addr <= {i_char_data[7:0], s2_vlow};
      s3_fg       <= i_char_data[10:8];
      s3_bg       <= i_char_data[14:12];
      s3_blink    <= i_char_data[15];
      s3_hlow     <= s2_hlow;
      s3_vis      <= s2_vis;
      s3_hs       <= s2_hs;
      s3_vs       <= s2_vs;
      s3_cur      <= s2_cur;
    end
  end

  // Stage 4: wait for the font ROM read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s4_fg    <= '0;
      s4_bg    <= '0;
      s4_blink <= 1'b0;
      s4_hlow  <= '0;
      s4_vis   <= 1'b0;
      s4_hs    <= 1'b0;
      s4_vs    <= 1'b0;
      s4_cur   <= 1'b0;
    end else begin
      s4_fg    <= s3_fg;
      s4_bg    <= s3_bg;
      s4_blink <= s3_blink;
      s4_hlow  <= s3_hlow;
      s4_vis   <= s3_vis;
      s4_hs    <= s3_hs;
      s4_vs    <= s3_vs;
      s4_cur   <= s3_cur;
    end
  end

  // Frame counter advances on each rising edge of the incoming vsync
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
    end else if (i_vsync && !s1_vs) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Pixel select and colour priority: cursor beats blink beats glyph bit
  always_comb begin
    pixel_bit   = i_font_data[3'd7 - s4_hlow];
    blink_phase = frame_cnt[BLINK_LOG2];
    pixel_on    = pixel_bit;
    if (s4_cur && blink_phase) begin
      pixel_on = 1'b1;
    end else if (s4_blink && !blink_phase) begin
      pixel_on = 1'b0;
    end
    colour = pixel_on ? s4_fg : s4_bg;
  end

  // Stage 5: registered RGB and aligned sync outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      o_red   <= (s4_vis && colour[0]) ? 3'b111 : 3'b000;
      o_green <= (s4_vis && colour[1]) ? 3'b111 : 3'b000;
      o_blue  <= (s4_vis && colour[2]) ? 3'b111 : 3'b000;
      o_hsync <= s4_hs;
      o_vsync <= s4_vs;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_mode_renderer.sv
// ============================================================================
//  Module   : tb_text_mode_renderer
//  Purpose  : Directed self-checking bench for text_mode_renderer with
//             synchronous character RAM and font ROM models.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_text_mode_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos, vpos;
  logic        visible, hsync, vsync;
  logic [11:0] char_addr, font_addr;
  logic [15:0] char_data;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [2:0]  red, green, blue;
  logic        hsync_o, vsync_o;
  logic [8:0]  rgb;

  logic [15:0] char_ram [0:4095];
  logic [7:0]  font_rom [0:4095];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rgb = {red, green, blue};

  text_mode_renderer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .i_visible    (visible),
    .i_hsync      (hsync),
    .i_vsync      (vsync),
    .o_char_addr  (char_addr),
    .i_char_data  (char_data),
    .o_font_addr  (font_addr),
    .i_font_data  (font_data),
    .i_cursor_en  (cursor_en),
    .i_cursor_col (cursor_col),
    .i_cursor_row (cursor_row),
    .o_red        (red),
    .o_green      (green),
    .o_blue       (blue),
    .o_hsync      (hsync_o),
    .o_vsync      (vsync_o)
  );

  // Synchronous memories: data valid the cycle after the address
  always @(posedge clk) begin
    char_data <= char_ram[char_addr];
    font_data <= font_rom[font_addr];
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic px(input logic [9:0] h, input logic [9:0] v, input logic vis);
    hpos    = h;
    vpos    = v;
    visible = vis;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      char_ram[i] = 16'h0000;
      font_rom[i] = 8'h00;
    end
    char_ram[0]     = 16'h4141;  // code 0x41, fg 001, bg 100
    char_ram[1]     = 16'h07FF;  // code 0xFF, fg 111, bg 000
    char_ram[162]   = 16'h0741;  // 'A', fg 7, bg 0
    char_ram[163]   = 16'h8742;  // blink, code 0x42, fg 7, bg 0
    font_rom[12'h413] = 8'h40;
    font_rom[12'h410] = 8'h80;
    font_rom[12'hFF0] = 8'hFF;
    font_rom[12'h420] = 8'h80;
    font_rom[12'h42E] = 8'h80;

    rst_n = 1'b0;
    hpos = 10'd17; vpos = 10'd35; visible = 1'b1; hsync = 1'b1; vsync = 1'b1;
    cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;

    // Reset state with non-zero inputs applied
    cyc(3);
    chk("rst_char_addr", char_addr, 12'h000);
    chk("rst_font_addr", font_addr, 12'h000);
    chk("rst_rgb", 12'(rgb), 12'h000);
    chk("rst_hsync", 12'(hsync_o), 12'h000);
    chk("rst_vsync", 12'(vsync_o), 12'h000);

    // Release: addressing and first-output latency
    hsync = 1'b0; vsync = 1'b0;
    rst_n = 1'b1;
    cyc(1);
    chk("char_addr_162", char_addr, 12'd162);
    cyc(2);
    chk("font_addr_413", font_addr, 12'h413);
    cyc(1);
    chk("rgb_before_latency", 12'(rgb), 12'h000);
    cyc(1);
    chk("rgb_first_valid", 12'(rgb), 12'o777);

    // Pixel select and colour
    px(10'd0, 10'd0, 1'b1); cyc(6);
    chk("rgb_fg_red", 12'(rgb), 12'o700);
    px(10'd1, 10'd0, 1'b1); cyc(6);
    chk("rgb_bg_blue", 12'(rgb), 12'o007);

    // Blanking
    px(10'd8, 10'd0, 1'b0); cyc(6);
    chk("rgb_blank", 12'(rgb), 12'o000);
    px(10'd8, 10'd0, 1'b1); cyc(6);
    chk("rgb_unblank", 12'(rgb), 12'o777);

    // Blink phase 0
    px(10'd24, 10'd32, 1'b1); cyc(6);
    chk("blink_p0_off", 12'(rgb), 12'o000);
    cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd2;
    px(10'd16, 10'd46, 1'b1); cyc(6);
    chk("cursor_p0_hidden", 12'(rgb), 12'o000);
    cursor_col = 7'd3;
    px(10'd24, 10'd46, 1'b1); cyc(6);
    chk("cursor_blink_p0", 12'(rgb), 12'o000);

    // Sync latency and width
    px(10'd8, 10'd0, 1'b0);
    hsync = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (k == 1) hsync = 1'b0;
      chk($sformatf("hsync_k%0d", k), 12'(hsync_o), 12'((k == 5) ? 1 : 0));
    end
    vsync = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k == 3) vsync = 1'b0;
      chk($sformatf("vsync_k%0d", k), 12'(vsync_o), 12'((k >= 5 && k <= 7) ? 1 : 0));
    end

    // Bring frame counter to 32 so the blink phase becomes 1
    repeat (31) begin
      vsync = 1'b1; cyc(1);
      vsync = 1'b0; cyc(1);
    end

    // Blink phase 1
    cursor_col = 7'd2;
    px(10'd16, 10'd46, 1'b1); cyc(6);
    chk("cursor_p1_shown", 12'(rgb), 12'o777);
    px(10'd16, 10'd45, 1'b1); cyc(6);
    chk("cursor_line13", 12'(rgb), 12'o000);
    px(10'd24, 10'd32, 1'b1); cyc(6);
    chk("blink_p1_on", 12'(rgb), 12'o777);
    cursor_col = 7'd3;
    px(10'd25, 10'd46, 1'b1); cyc(6);
    chk("cursor_blink_p1", 12'(rgb), 12'o777);

    // Asynchronous reset mid-line
    hsync = 1'b1; cyc(6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", 12'(rgb), 12'o000);
    chk("arst_char_addr", char_addr, 12'h000);
    chk("arst_hsync", 12'(hsync_o), 12'h000);
    @(negedge clk);
    hsync = 1'b0;
    cursor_en = 1'b0;
    px(10'd0, 10'd0, 1'b1);
    rst_n = 1'b1;
    cyc(4);
    chk("arst_rel_k4", 12'(rgb), 12'o000);
    cyc(1);
    chk("arst_rel_k5", 12'(rgb), 12'o700);
    px(10'd24, 10'd32, 1'b1); cyc(6);
    chk("frame_cnt_restart", 12'(rgb), 12'o000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
